serdes_unpack: RTL and testbench
================================

// Module: serdes_unpack
// PURPOSE
//  Inverse of the write-side packer: takes a dense stream of PACK_COUNT-op words from the
//  memory side and re-slices it into UNPACK_COUNT-lane words holding cfg_count valid ops each
//  (upper lanes zero). Sits between the read buffer and the PE array input.
//  Moves one op per cycle through an internal serial path.
//  Flush emits the final partial word zero-padded.
// PARAMETERS
//  PACK_COUNT    10                        ops per packed input word
//  UNPACK_COUNT  10                        lanes per unpacked output word
//  OP_WIDTH      16                        bits per op
//  PACK_WIDTH    PACK_COUNT*OP_WIDTH       input data width
//  UNPACK_WIDTH  UNPACK_COUNT*OP_WIDTH     output data width
//  COUNT_W       C_LOG_2(UNPACK_COUNT+1)   width of cfg_count
// PORTS
//  clk            in   1             clock
//  reset          in   1             asynchronous, active-high reset
//  cfg_count      in   COUNT_W       valid ops per output word; sampled at word start
//  s_read_flush   in   1             end-of-stream pulse
//  s_read_req     in   1             input word valid
//  s_read_ready   out  1             input accepted when s_read_req && s_read_ready
//  s_read_data    in   PACK_WIDTH    packed ops; op0 in bits [OP_WIDTH-1:0]
//  m_read_req     out  1             output word valid; held until m_read_ready
//  m_read_ready   in   1             downstream accept
//  m_read_data    out  UNPACK_WIDTH  unpacked word; lane0 in LSBs; lanes >= word_cnt are 0
// BEHAVIOUR
//  Reset (async): state=IDLE, src_left=0, dst_idx=0, dst_data=0, flush_sticky=0,
//   m_read_req=0, s_read_ready=0 while reset is high.
//  Registers:
//   - src_data/src_left (0..PACK_COUNT): input holding register and its remaining ops.
//   - dst_data/dst_idx: assembly register and its next lane.
//   - word_cnt: latched count for the current output word.
//  s_read_ready = (src_left==0) && !reset. On accept: src_data<=s_read_data, src_left<=PACK_COUNT.
//  word_cnt latch: cfg_count==0 or cfg_count>UNPACK_COUNT latches as UNPACK_COUNT.
//  FSM:
//   - IDLE: latch word_cnt from cfg_count -> FILL next cycle.
//   - FILL, each cycle with src_left>0:
//     - lane[dst_idx] <= src_data[OP_WIDTH-1:0];
//     - src_data >>= OP_WIDTH; src_left--; dst_idx++.
//     - When dst_idx+1==word_cnt on this move -> SEND.
//   - FILL, src_left==0 && flush_sticky:
//     - dst_idx>0: -> SEND (zero-padded partial word).
//     - dst_idx==0: clear flush_sticky, stay in FILL; no word emitted.
//   - SEND: m_read_req=1, m_read_data=dst_data.
//     - On m_read_ready: dst_data<=0, dst_idx<=0, latch new word_cnt from cfg_count,
//       clear flush_sticky if src_left==0 -> FILL.
//     - No op moves while in SEND; src is held, so s_read_ready stays low if src_left>0.
//  flush_sticky: set by s_read_flush, independent of state. A flush with ops still in src
//   drains them normally first; only the last partial word is padded.
//  Simultaneous events:
//   - Accept plus move in one cycle is impossible: accept only occurs with src_left==0.
//   - s_read_flush concurrent with an accept: data is kept, flush applies after it drains.
//  Latency: first op moves the cycle after src load. m_read_req rises word_cnt cycles
//   after src load when no new input word is needed. Each input refill costs 1 bubble.
//  Throughput: 1 op/cycle, excluding SEND stall and refill bubble.
// STRUCTURE
//  Shared include/package (common.vh): C_LOG_2, state localparams IDLE/FILL/SEND (2-bit),
//   lane-select helper.
//  One sub-module: piso (parallel-in serial-out): load, shift enable, op0 output, remaining count.
//   Counterpart of sipo; holds src_data/src_left.
//  Top level holds the FSM, dst assembly register, word_cnt and flush logic.
// TESTING (PACK=4, UNPACK=4, OP=8)
//  Aligned case: cfg=4, input 0x04030201, m_read_ready=1
//   -> one output 0x04030201; m_read_req 4 cycles after load.
//  Re-slice case: cfg=3, inputs 0x04030201, 0x08070605, then flush
//   -> outputs 0x00030201, 0x00060504, 0x00000807; then idle with flush_sticky=0.
//  Backpressure: cfg=2, m_read_ready low for 10 cycles
//   -> m_read_req and data 0x00000201 stable; s_read_ready=0; nothing lost after release.
//  Empty flush: flush with src_left==0 and dst_idx==0 -> no m_read_req; flush_sticky cleared.
//  Config clamping: cfg=0 and cfg=7 -> both behave as 4-op words.
//  Mid-operation reset: assert reset with 2 ops in dst -> m_read_req=0 immediately;
//   after release, cfg=4 with input 0x0D0C0B0A -> output 0x0D0C0B0A with no stale lanes.

Source files
------------

// File: rtl/serdes_unpack_pkg.sv
`default_nettype none
// ============================================================================
// Module  : serdes_unpack_pkg
// Brief   : Shared constants and helpers for the read-side op unpacker.
// Revision: 1.0 - initial release
// ============================================================================
package serdes_unpack_pkg;

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_fill = 2'd1;
    localparam logic [1:0] c_st_send = 2'd2;

    // Ceiling log2; used to size counters that must hold the value itself.
    function automatic int C_LOG_2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

    function automatic int lane_lsb(input int lane, input int op_width);
        return lane * op_width;
    endfunction

endpackage
`default_nettype wire

// File: rtl/serdes_unpack_piso.sv
`default_nettype none
// ============================================================================
// Module  : serdes_unpack_piso
// Brief   : Parallel-in serial-out holding register, one op out per shift.
// Revision: 1.0 - initial release
// ============================================================================
module serdes_unpack_piso
    import serdes_unpack_pkg::*;
#(
    parameter int PACK_COUNT = 10,
    parameter int OP_WIDTH   = 16,
    parameter int PACK_WIDTH = PACK_COUNT * OP_WIDTH,
    parameter int LEFT_W     = C_LOG_2(PACK_COUNT + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_load,
    input  logic                  i_shift,
    input  logic [PACK_WIDTH-1:0] i_data,
    output logic [OP_WIDTH-1:0]   o_op,
    output logic [LEFT_W-1:0]     o_left
);

    logic [PACK_WIDTH-1:0] r_data;
    logic [LEFT_W-1:0]     r_left;

    // Load and shift are mutually exclusive: load only happens when empty.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data <= '0;
            r_left <= '0;
        end else if (i_load) begin
            r_data <= i_data;
            r_left <= LEFT_W'(PACK_COUNT);
        end else if (i_shift) begin
            r_data <= r_data >> OP_WIDTH;
            r_left <= r_left - 1'b1;
        end
    end

    assign o_op   = r_data[OP_WIDTH-1:0];
    assign o_left = r_left;

endmodule
`default_nettype wire

// File: rtl/serdes_unpack.sv
`default_nettype none
// ============================================================================
// Module  : serdes_unpack
// Brief   : Re-slices packed op words into cfg_count-op lane words, one op/cycle.
// Revision: 1.0 - initial release
// ============================================================================
module serdes_unpack
    import serdes_unpack_pkg::*;
#(
    parameter int PACK_COUNT   = 10,
    parameter int UNPACK_COUNT = 10,
    parameter int OP_WIDTH     = 16,
    parameter int PACK_WIDTH   = PACK_COUNT * OP_WIDTH,
    parameter int UNPACK_WIDTH = UNPACK_COUNT * OP_WIDTH,
    parameter int COUNT_W      = C_LOG_2(UNPACK_COUNT + 1)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [COUNT_W-1:0]      cfg_count,
    input  logic                    s_read_flush,
    input  logic                    s_read_req,
    output logic                    s_read_ready,
    input  logic [PACK_WIDTH-1:0]   s_read_data,
    output logic                    m_read_req,
    input  logic                    m_read_ready,
    output logic [UNPACK_WIDTH-1:0] m_read_data
);

    localparam int                 c_left_w  = C_LOG_2(PACK_COUNT + 1);
    localparam logic [COUNT_W-1:0] c_max_cnt = COUNT_W'(UNPACK_COUNT);

    logic [1:0]              r_state;
    logic [UNPACK_WIDTH-1:0] r_dst_data;
    logic [COUNT_W-1:0]      r_dst_idx;
    logic [COUNT_W-1:0]      r_word_cnt;
    logic                    r_flush_sticky;

    logic [OP_WIDTH-1:0]     w_src_op;
    logic [c_left_w-1:0]     w_src_left;
    logic                    w_src_empty;
    logic                    w_accept;
    logic                    w_move;
    logic                    w_flush_clr;
    logic [COUNT_W-1:0]      w_cfg_cnt;
    logic [COUNT_W-1:0]      w_idx_next;

    assign w_src_empty  = (w_src_left == '0);
    assign s_read_ready = w_src_empty && !reset;
    assign w_accept     = s_read_req && s_read_ready;
    assign w_move       = (r_state == c_st_fill) && !w_src_empty;
    assign w_idx_next   = r_dst_idx + 1'b1;
    assign w_cfg_cnt    = ((cfg_count == '0) || (cfg_count > c_max_cnt)) ? c_max_cnt : cfg_count;

    // A flush is consumed once the source is dry: either nothing was pending,
    // or the word carrying the last ops has just been handed off.
    assign w_flush_clr = ((r_state == c_st_fill) && w_src_empty && r_flush_sticky && (r_dst_idx == '0))
                      || ((r_state == c_st_send) && m_read_ready && w_src_empty);

    serdes_unpack_piso #(
        .PACK_COUNT (PACK_COUNT),
        .OP_WIDTH   (OP_WIDTH),
        .PACK_WIDTH (PACK_WIDTH),
        .LEFT_W     (c_left_w)
    ) u_piso (
        .clk     (clk),
        .rst     (reset),
        .i_load  (w_accept),
        .i_shift (w_move),
        .i_data  (s_read_data),
        .o_op    (w_src_op),
        .o_left  (w_src_left)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= c_st_idle;
            r_dst_data <= '0;
            r_dst_idx  <= '0;
            r_word_cnt <= c_max_cnt;
        end else begin
            case (r_state)
                c_st_idle: begin
                    r_word_cnt <= w_cfg_cnt;
                    r_state    <= c_st_fill;
                end
                c_st_fill: begin
                    if (w_move) begin
                        r_dst_data[lane_lsb(int'(r_dst_idx), OP_WIDTH) +: OP_WIDTH] <= w_src_op;
                        r_dst_idx <= w_idx_next;
                        if (w_idx_next == r_word_cnt) r_state <= c_st_send;
                    end else if (r_flush_sticky && (r_dst_idx != '0)) begin
                        r_state <= c_st_send;
                    end
                end
                c_st_send: begin
                    if (m_read_ready) begin
                        r_dst_data <= '0;
                        r_dst_idx  <= '0;
                        r_word_cnt <= w_cfg_cnt;
                        r_state    <= c_st_fill;
                    end
                end
                default: r_state <= c_st_idle;
            endcase
        end
    end

    // A new flush pulse wins over a same-cycle clear so it is never lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_flush_sticky <= 1'b0;
        end else if (s_read_flush) begin
            r_flush_sticky <= 1'b1;
        end else if (w_flush_clr) begin
            r_flush_sticky <= 1'b0;
        end
    end

    assign m_read_req  = (r_state == c_st_send);
    assign m_read_data = r_dst_data;

endmodule
`default_nettype wire

// File: tb/tb_serdes_unpack.sv
`default_nettype none
// ============================================================================
// Module  : tb_serdes_unpack
// Brief   : Self-checking bench: op-queue reference model plus directed cases.
// Revision: 1.0 - initial release
// ============================================================================
module tb_serdes_unpack;

    localparam int P  = 4;
    localparam int U  = 4;
    localparam int OW = 8;
    localparam int PW = P * OW;
    localparam int UW = U * OW;
    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [CW-1:0] cfg_count = 3'd4;
    logic          s_read_flush = 1'b0;
    logic          s_read_req = 1'b0;
    logic          s_read_ready;
    logic [PW-1:0] s_read_data = '0;
    logic          m_read_req;
    logic          m_read_ready;
    logic [UW-1:0] m_read_data;

    logic          rand_mode = 1'b0;
    logic          rand_ready = 1'b1;
    logic          fixed_ready = 1'b1;
    assign m_read_ready = rand_mode ? rand_ready : fixed_ready;

    serdes_unpack #(
        .PACK_COUNT   (P),
        .UNPACK_COUNT (U),
        .OP_WIDTH     (OW)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .cfg_count    (cfg_count),
        .s_read_flush (s_read_flush),
        .s_read_req   (s_read_req),
        .s_read_ready (s_read_ready),
        .s_read_data  (s_read_data),
        .m_read_req   (m_read_req),
        .m_read_ready (m_read_ready),
        .m_read_data  (m_read_data)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int load_cyc = 0;
    int first_req_cyc = -1;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) rand_ready <= ($urandom_range(0, 3) != 0);

    function automatic void check(input string name, input longint unsigned act, input longint unsigned exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endfunction

    function automatic void fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s (t=%0t)", name, $time);
    endfunction

    function automatic int clamp(input int c);
        return (c == 0 || c > U) ? U : c;
    endfunction

    // Reference model: ops in arrival order; each word takes the next word_cnt
    // ops, or whatever is left when a flush is pending.
    logic [OW-1:0] op_q[$];
    logic [UW-1:0] got_q[$];
    int  cur_cnt = U;
    bit  idle_latch = 1'b1;
    bit  flush_pend = 1'b0;

    always @(negedge clk) begin : monitor
        int n;
        logic [UW-1:0] exp;
        if (reset) begin
            op_q.delete();
            flush_pend = 1'b0;
            idle_latch = 1'b1;
        end else begin
            if (idle_latch) begin
                cur_cnt    = clamp(int'(cfg_count));
                idle_latch = 1'b0;
            end
            if (m_read_req) begin
                n   = (op_q.size() >= cur_cnt) ? cur_cnt : op_q.size();
                exp = '0;
                for (int i = 0; i < n; i++) exp[i*OW +: OW] = op_q[i];
                if (!flush_pend) check("word_len", n, cur_cnt);
                check("word_nonempty", (n > 0), 1);
                check("out_data", m_read_data, exp);
                if (first_req_cyc < 0) first_req_cyc = cyc;
                if (m_read_ready) begin
                    got_q.push_back(m_read_data);
                    for (int i = 0; i < n; i++) void'(op_q.pop_front());
                    cur_cnt = clamp(int'(cfg_count));
                end
            end
            if (s_read_req && s_read_ready)
                for (int i = 0; i < P; i++) op_q.push_back(s_read_data[i*OW +: OW]);
            if (s_read_flush) flush_pend = 1'b1;
            else if (op_q.size() == 0) flush_pend = 1'b0;
        end
    end

    function automatic logic [UW-1:0] got(input int i);
        return (got_q.size() > i) ? got_q[i] : {UW{1'b1}};
    endfunction

    // All stimulus tasks start and end #1 after a rising edge.
    task automatic do_reset(input int cfg, input logic rdy);
        reset        = 1'b1;
        s_read_req   = 1'b0;
        s_read_flush = 1'b0;
        cfg_count    = CW'(cfg);
        fixed_ready  = rdy;
        first_req_cyc = -1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        got_q.delete();
    endtask

    task automatic send_word(input logic [PW-1:0] d);
        int t;
        t = 0;
        s_read_req  = 1'b1;
        s_read_data = d;
        @(negedge clk);
        while (!s_read_ready && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (t >= 500) fail("accept_timeout");
        @(posedge clk);
        #1;
        s_read_req = 1'b0;
        load_cyc   = cyc;
    endtask

    task automatic pulse_flush();
        s_read_flush = 1'b1;
        @(posedge clk);
        #1 s_read_flush = 1'b0;
    endtask

    task automatic wait_idle();
        int quiet;
        int t;
        quiet = 0;
        t = 0;
        while (quiet < 6 && t < 3000) begin
            @(negedge clk);
            t++;
            if (op_q.size() == 0 && !m_read_req) quiet++;
            else quiet = 0;
        end
        if (quiet < 6) fail("drain_timeout");
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req();
        int t;
        t = 0;
        while (!m_read_req && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!m_read_req) fail("req_timeout");
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL global_timeout");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int nw;
        bit seen;
        @(posedge clk);
        #1;
        check("rst_m_req", m_read_req, 0);
        check("rst_s_ready", s_read_ready, 0);
        check("rst_m_data", m_read_data, 0);
        check("rst_dst_idx", dut.r_dst_idx, 0);
        check("rst_flush", dut.r_flush_sticky, 0);

        // Aligned word and first-word latency
        do_reset(4, 1'b1);
        send_word(32'h04030201);
        wait_idle();
        check("aligned_cnt", got_q.size(), 1);
        check("aligned_w0", got(0), 32'h04030201);
        check("aligned_latency", first_req_cyc - load_cyc, 4);

        // Re-slice into 3-op words with a final flushed partial
        do_reset(3, 1'b1);
        send_word(32'h04030201);
        send_word(32'h08070605);
        pulse_flush();
        wait_idle();
        check("reslice_cnt", got_q.size(), 3);
        check("reslice_w0", got(0), 32'h00030201);
        check("reslice_w1", got(1), 32'h00060504);
        check("reslice_w2", got(2), 32'h00000807);
        check("reslice_flush_clr", dut.r_flush_sticky, 0);

        // Backpressure holds the word and blocks refill
        do_reset(2, 1'b0);
        send_word(32'h04030201);
        wait_req();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("bp_req", m_read_req, 1);
            check("bp_data", m_read_data, 32'h00000201);
            check("bp_s_ready", s_read_ready, 0);
        end
        @(posedge clk);
        #1 fixed_ready = 1'b1;
        wait_idle();
        check("bp_cnt", got_q.size(), 2);
        check("bp_w0", got(0), 32'h00000201);
        check("bp_w1", got(1), 32'h00000403);

        // Flush with nothing pending emits nothing
        do_reset(4, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        pulse_flush();
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (m_read_req) seen = 1'b1;
        end
        check("empty_flush_no_req", seen, 0);
        check("empty_flush_clr", dut.r_flush_sticky, 0);
        @(posedge clk);
        #1;

        // Out-of-range counts clamp to full words
        for (int k = 0; k < 2; k++) begin
            do_reset((k == 0) ? 0 : 7, 1'b1);
            send_word(32'h04030201);
            wait_idle();
            check("clamp_cnt", got_q.size(), 1);
            check("clamp_w0", got(0), 32'h04030201);
        end

        // Reset while a 2-op word is waiting, then a clean word
        do_reset(2, 1'b0);
        send_word(32'h04030201);
        wait_req();
        @(posedge clk);
        #1 reset = 1'b1;
        #1;
        check("midrst_m_req", m_read_req, 0);
        check("midrst_s_ready", s_read_ready, 0);
        check("midrst_dst_idx", dut.r_dst_idx, 0);
        @(posedge clk);
        #1;
        do_reset(4, 1'b1);
        send_word(32'h0D0C0B0A);
        wait_idle();
        check("midrst_cnt", got_q.size(), 1);
        check("midrst_w0", got(0), 32'h0D0C0B0A);

        // Randomized segments against the queue model
        for (int seg = 0; seg < 12; seg++) begin
            do_reset($urandom_range(0, 7), 1'b1);
            rand_mode = 1'b1;
            nw = $urandom_range(1, 6);
            for (int w = 0; w < nw; w++) begin
                repeat ($urandom_range(0, 3)) begin
                    @(posedge clk);
                    #1;
                end
                if ($urandom_range(0, 3) == 0) cfg_count = CW'($urandom_range(0, 7));
                send_word($urandom);
            end
            pulse_flush();
            wait_idle();
            check("rand_drained", op_q.size(), 0);
            rand_mode = 1'b0;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
